// File: rtl/mouse_packet_decoder.sv
// mouse_packet_decoder: 3-byte PS/2 mouse packet to clamped cursor position, buttons and click pulse
// Define PKT_TIMEOUT_EN to drop partial packets after TIMEOUT idle cycles between bytes.
module mouse_packet_decoder #(
  parameter int H_MAX   = 639,
  parameter int V_MAX   = 479,
  parameter int X_INIT  = 320,
  parameter int Y_INIT  = 240,
  parameter int TIMEOUT = 100000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] rx_data,
  input  logic       rx_done_tick,
  output logic [9:0] px_reg,
  output logic [9:0] py_reg,
  output logic       mouseclick,
  output logic       btn_left,
  output logic       btn_right,
  output logic       pkt_tick
);
  typedef enum logic [1:0] {WAIT_B0, WAIT_B1, WAIT_B2, UPDATE} state_t;
  state_t state_q, state_d;
  logic [7:0] b0_q, b0_d, dx_q, dx_d, dy_q, dy_d;
  logic [9:0] px_q, px_d, py_q, py_d, x_clamp, y_clamp;
  logic [11:0] x_sum, y_sum;
  logic click_q, click_d, bl_q, bl_d, br_q, br_d, tick_q, tick_d;
  logic tmo;
`ifdef PKT_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] cnt_q, cnt_d;
  always_comb begin
    tmo = cnt_q == CW'(TIMEOUT);
    cnt_d = ((state_q == WAIT_B1 || state_q == WAIT_B2) && !rx_done_tick && !tmo) ? cnt_q + 1'b1 : '0;
  end
  always_ff @(posedge clk) cnt_q <= reset ? '0 : cnt_d;
`else
  assign tmo = 1'b0;
`endif
  // PS/2 +y is up while screen y grows downward, so dy is subtracted
  always_comb begin
    x_sum = {2'b00, px_q} + {{4{b0_q[4]}}, dx_q};
    y_sum = {2'b00, py_q} - {{4{b0_q[5]}}, dy_q};
    x_clamp = x_sum[11] ? 10'd0 : (x_sum > 12'(H_MAX)) ? 10'(H_MAX) : x_sum[9:0];
    y_clamp = y_sum[11] ? 10'd0 : (y_sum > 12'(V_MAX)) ? 10'(V_MAX) : y_sum[9:0];
  end
  always_comb begin
    state_d = state_q;
    b0_d = b0_q;
    dx_d = dx_q;
    dy_d = dy_q;
    px_d = px_q;
    py_d = py_q;
    bl_d = bl_q;
    br_d = br_q;
    click_d = 1'b0;
    tick_d = 1'b0;
    case (state_q)
      WAIT_B0: if (rx_done_tick && rx_data[3]) begin
        b0_d = rx_data;
        state_d = WAIT_B1;
      end
      WAIT_B1: if (rx_done_tick) begin
        dx_d = rx_data;
        state_d = WAIT_B2;
      end else if (tmo) state_d = WAIT_B0;
      WAIT_B2: if (rx_done_tick) begin
        dy_d = rx_data;
        state_d = UPDATE;
      end else if (tmo) state_d = WAIT_B0;
      default: begin
        state_d = WAIT_B0;
        px_d = b0_q[6] ? px_q : x_clamp;
        py_d = b0_q[7] ? py_q : y_clamp;
        bl_d = b0_q[0];
        br_d = b0_q[1];
        click_d = b0_q[0] && !bl_q;
        tick_d = 1'b1;
      end
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= WAIT_B0;
      b0_q <= '0;
      dx_q <= '0;
      dy_q <= '0;
      px_q <= 10'(X_INIT);
      py_q <= 10'(Y_INIT);
      bl_q <= 1'b0;
      br_q <= 1'b0;
      click_q <= 1'b0;
      tick_q <= 1'b0;
    end else begin
      state_q <= state_d;
      b0_q <= b0_d;
      dx_q <= dx_d;
      dy_q <= dy_d;
      px_q <= px_d;
      py_q <= py_d;
      bl_q <= bl_d;
      br_q <= br_d;
      click_q <= click_d;
      tick_q <= tick_d;
    end
  end
  assign px_reg = px_q;
  assign py_reg = py_q;
  assign mouseclick = click_q;
  assign btn_left = bl_q;
  assign btn_right = br_q;
  assign pkt_tick = tick_q;
endmodule
